// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: FSM states, access size codes,
// bus widths and the bit positions of every field on the EXE->MEM and MEM->WB buses.
package mem_pkg;

    localparam int MEM_BUS_IN_W  = 156;
    localparam int MEM_BUS_OUT_W = 153;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // EXE->MEM bus, LSB positions of each field
    localparam int IN_LD       = 155;
    localparam int IN_ST       = 154;
    localparam int IN_SIZE     = 152;
    localparam int IN_UNS      = 151;
    localparam int IN_SDATA    = 119;
    localparam int IN_EXE      = 87;
    localparam int IN_LO       = 55;
    localparam int IN_FLAGS    = 49;
    localparam int IN_CP0R     = 41;
    localparam int IN_EXC      = 38;
    localparam int IN_WEN      = 37;
    localparam int IN_WDEST    = 32;
    localparam int IN_PC       = 0;

    // MEM->WB bus, LSB positions of each field
    localparam int OUT_WEN     = 152;
    localparam int OUT_WDEST   = 147;
    localparam int OUT_RESULT  = 115;
    localparam int OUT_LO      = 83;
    localparam int OUT_FLAGS   = 77;
    localparam int OUT_CP0R    = 69;
    localparam int OUT_EXC     = 66;
    localparam int OUT_ADEL    = 65;
    localparam int OUT_ADES    = 64;
    localparam int OUT_BADV    = 32;
    localparam int OUT_PC      = 0;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for data memory: store strobes and replicated write data,
// plus lane selection and sign/zero extension of returned load data.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_uns,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
        case (i_size)
            SZ_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            SZ_H: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            SZ_B:    o_load_data = {{24{w_byte[7] & ~i_uns}}, w_byte};
            SZ_H:    o_load_data = {{16{w_half[15] & ~i_uns}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one data-memory transaction per instruction over a
// req/addr_ok/data_ok handshake. Build macro MEM_ADDR_CHECK_EN enables alignment faults.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MEM_IDLE | waiting for an instruction; non-memory ops complete here
// MEM_REQ  | data_req held with stable fields until data_addr_ok
// MEM_WAIT | request accepted, waiting for data_data_ok (or draining)
// MEM_DONE | result held for write-back until WB_allow_in
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_CHECK = 1,
    parameter int BUS_IN_W   = MEM_BUS_IN_W,
    parameter int BUS_OUT_W  = MEM_BUS_OUT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MEM_valid,
    input  logic [BUS_IN_W-1:0]  EXE_MEM_bus_r,
    input  logic                 WB_allow_in,
    input  logic                 cancel,
    output logic                 MEM_over,
    output logic                 MEM_allow_in,
    output logic [BUS_OUT_W-1:0] MEM_WB_bus,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          MEM_result,
    output logic                 data_req,
    output logic                 data_wr,
    output logic [1:0]           data_size,
    output logic [31:0]          data_addr,
    output logic [3:0]           data_wstrb,
    output logic [31:0]          data_wdata,
    input  logic                 data_addr_ok,
    input  logic                 data_data_ok,
    input  logic [31:0]          data_rdata
);

    mem_state_t  r_state;
    mem_state_t  w_next;
    logic [31:0] r_ldata;
    logic        r_drop;

    logic        w_ld, w_st, w_uns, w_is_mem;
    logic [1:0]  w_size;
    logic [31:0] w_exe, w_addr;
    logic        w_addr_err, w_adel, w_ades;
    logic [31:0] w_badvaddr, w_mem_result, w_load_data, w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_req, w_over;

    assign w_ld     = EXE_MEM_bus_r[IN_LD];
    assign w_st     = EXE_MEM_bus_r[IN_ST];
    assign w_size   = EXE_MEM_bus_r[IN_SIZE +: 2];
    assign w_uns    = EXE_MEM_bus_r[IN_UNS];
    assign w_exe    = EXE_MEM_bus_r[IN_EXE +: 32];
    assign w_is_mem = w_ld | w_st;

`ifdef MEM_ADDR_CHECK_EN
    logic w_misalign;
    assign w_misalign = ((w_size == SZ_H) && w_exe[0]) ||
                        ((w_size == SZ_W) && (w_exe[1:0] != 2'b00));
    assign w_addr_err = (ADDR_CHECK != 0) && w_misalign;
    assign w_addr     = w_exe;
`else
    assign w_addr_err = 1'b0;
    // Without fault detection the low bits are silently masked to the access size.
    always_comb begin
        w_addr = w_exe;
        if (w_size == SZ_H) w_addr[0]   = 1'b0;
        if (w_size == SZ_W) w_addr[1:0] = 2'b00;
    end
`endif

    assign w_adel     = w_ld & w_addr_err;
    assign w_ades     = w_st & w_addr_err;
    assign w_badvaddr = (w_adel | w_ades) ? w_exe : 32'd0;

    mem_align u_align (
        .i_size       (w_size),
        .i_addr_lo    (w_addr[1:0]),
        .i_uns        (w_uns),
        .i_store_data (EXE_MEM_bus_r[IN_SDATA +: 32]),
        .i_rdata      (r_ldata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_over = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (MEM_valid && !cancel) begin
                    if (w_is_mem && !w_addr_err) begin
                        w_next = MEM_REQ;
                    end else begin
                        w_over = 1'b1;
                        if (!WB_allow_in) w_next = MEM_DONE;
                    end
                end
            end
            MEM_REQ: begin
                w_req = 1'b1;
                // An accepted request must be drained even if cancel arrives alongside it.
                if (data_addr_ok)  w_next = MEM_WAIT;
                else if (cancel)   w_next = MEM_IDLE;
            end
            MEM_WAIT: begin
                if (data_data_ok) w_next = (r_drop || cancel) ? MEM_IDLE : MEM_DONE;
            end
            MEM_DONE: begin
                if (cancel) begin
                    w_next = MEM_IDLE;
                end else begin
                    w_over = 1'b1;
                    if (WB_allow_in) w_next = MEM_IDLE;
                end
            end
            default: w_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MEM_IDLE;
            r_ldata <= 32'd0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == MEM_WAIT && data_data_ok) begin
                if (!(r_drop || cancel)) r_ldata <= data_rdata;
                r_drop <= 1'b0;
            end else if ((r_state == MEM_WAIT && cancel) ||
                         (r_state == MEM_REQ && data_addr_ok && cancel)) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign w_mem_result = (w_ld && !w_addr_err) ? w_load_data : w_exe;

    assign data_req     = w_req;
    assign data_wr      = w_st;
    assign data_size    = w_size;
    assign data_addr    = w_addr;
    assign data_wstrb   = w_st ? w_wstrb : 4'b0000;
    assign data_wdata   = w_wdata;

    assign MEM_over     = w_over;
    assign MEM_allow_in = (r_state != MEM_WAIT) && (!MEM_valid || (w_over && WB_allow_in));
    assign MEM_wdest    = MEM_valid ? EXE_MEM_bus_r[IN_WDEST +: 5] : 5'd0;
    assign MEM_result   = w_mem_result;

    assign MEM_WB_bus = {
        EXE_MEM_bus_r[IN_WEN],
        EXE_MEM_bus_r[IN_WDEST +: 5],
        w_mem_result,
        EXE_MEM_bus_r[IN_LO +: 32],
        EXE_MEM_bus_r[IN_FLAGS +: 6],
        EXE_MEM_bus_r[IN_CP0R +: 8],
        EXE_MEM_bus_r[IN_EXC +: 3],
        w_adel,
        w_ades,
        w_badvaddr,
        EXE_MEM_bus_r[IN_PC +: 32]
    };

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores with hand-driven memory handshakes,
// cancel drain, write-back stall, async reset. Honours MEM_ADDR_CHECK_EN if defined.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         MEM_valid;
    logic [155:0] EXE_MEM_bus_r;
    logic         WB_allow_in;
    logic         cancel;
    logic         MEM_over;
    logic         MEM_allow_in;
    logic [152:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_result;
    logic         data_req;
    logic         data_wr;
    logic [1:0]   data_size;
    logic [31:0]  data_addr;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_wdata;
    logic         data_addr_ok;
    logic         data_data_ok;
    logic [31:0]  data_rdata;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] LO_C = 32'h0BAD_F00D;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .MEM_valid     (MEM_valid),
        .EXE_MEM_bus_r (EXE_MEM_bus_r),
        .WB_allow_in   (WB_allow_in),
        .cancel        (cancel),
        .MEM_over      (MEM_over),
        .MEM_allow_in  (MEM_allow_in),
        .MEM_WB_bus    (MEM_WB_bus),
        .MEM_wdest     (MEM_wdest),
        .MEM_result    (MEM_result),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wstrb    (data_wstrb),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata)
    );

    function automatic logic [155:0] mk_in(input logic ld, input logic st, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] sdata,
                                           input logic [31:0] exe, input logic [4:0] wd,
                                           input logic [31:0] pc);
        return {ld, st, sz, uns, sdata, exe, LO_C, 6'b101001, 8'h3C, 3'b010, 1'b1, wd, pc};
    endfunction

    function automatic logic [152:0] mk_wb(input logic [4:0] wd, input logic [31:0] res,
                                           input logic adel, input logic ades,
                                           input logic [31:0] badv, input logic [31:0] pc);
        return {1'b1, wd, res, LO_C, 6'b101001, 8'h3C, 3'b010, adel, ades, badv, pc};
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with addr_ok in the first REQ cycle and data_ok one cycle later.
    task automatic run_load(input string tag, input logic [155:0] bus, input logic [31:0] exp_addr,
                            input logic [31:0] rdata, input logic [31:0] exp_res,
                            input logic [152:0] exp_wb);
        MEM_valid = 1'b1; EXE_MEM_bus_r = bus; WB_allow_in = 1'b1;
        #1;
        check({tag, "_idle_req"}, data_req, 1'b0);
        check({tag, "_idle_allow"}, MEM_allow_in, 1'b0);
        tick();
        data_addr_ok = 1'b1;
        #1;
        check({tag, "_req"}, data_req, 1'b1);
        check({tag, "_wr"}, data_wr, 1'b0);
        check({tag, "_addr"}, data_addr, exp_addr);
        check({tag, "_wstrb"}, data_wstrb, 4'b0000);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata;
        #1;
        check({tag, "_wait_req"}, data_req, 1'b0);
        check({tag, "_wait_over"}, MEM_over, 1'b0);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        check({tag, "_over"}, MEM_over, 1'b1);
        check({tag, "_result"}, MEM_result, exp_res);
        check({tag, "_allow"}, MEM_allow_in, 1'b1);
        check({tag, "_wbbus"}, MEM_WB_bus, exp_wb);
        tick();
        MEM_valid = 1'b0;
        #1;
        check({tag, "_after"}, MEM_over, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MEM_valid = 1'b0; EXE_MEM_bus_r = '0; WB_allow_in = 1'b1; cancel = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        check("rst_req", data_req, 1'b0);
        check("rst_over", MEM_over, 1'b0);
        check("rst_allow", MEM_allow_in, 1'b1);
        check("rst_wdest", MEM_wdest, 5'd0);
        tick();
        reset = 1'b0;
        tick();

        run_load("lw", mk_in(1, 0, 2'd2, 0, 32'h0, 32'h0000_1004, 5'd5, 32'hBFC0_0000),
                 32'h0000_1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                 mk_wb(5'd5, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'hBFC0_0000));
        run_load("lb", mk_in(1, 0, 2'd0, 0, 32'h0, 32'h0000_1003, 5'd6, 32'hBFC0_0004),
                 32'h0000_1003, 32'h8011_2233, 32'hFFFF_FF80,
                 mk_wb(5'd6, 32'hFFFF_FF80, 0, 0, 32'h0, 32'hBFC0_0004));
        run_load("lbu", mk_in(1, 0, 2'd0, 1, 32'h0, 32'h0000_1003, 5'd6, 32'hBFC0_0008),
                 32'h0000_1003, 32'h8011_2233, 32'h0000_0080,
                 mk_wb(5'd6, 32'h0000_0080, 0, 0, 32'h0, 32'hBFC0_0008));
        run_load("lh", mk_in(1, 0, 2'd1, 0, 32'h0, 32'h0000_1000, 5'd8, 32'hBFC0_000C),
                 32'h0000_1000, 32'h1234_8765, 32'hFFFF_8765,
                 mk_wb(5'd8, 32'hFFFF_8765, 0, 0, 32'h0, 32'hBFC0_000C));
        run_load("lhu", mk_in(1, 0, 2'd1, 1, 32'h0, 32'h0000_1002, 5'd9, 32'hBFC0_0010),
                 32'h0000_1002, 32'h8001_7FFF, 32'h0000_8001,
                 mk_wb(5'd9, 32'h0000_8001, 0, 0, 32'h0, 32'hBFC0_0010));

        // sh at 0x1002
        MEM_valid = 1'b1; EXE_MEM_bus_r = mk_in(0, 1, 2'd1, 0, 32'h0000_ABCD, 32'h0000_1002, 5'd0, 32'hBFC0_0014);
        tick();
        data_addr_ok = 1'b1;
        #1;
        check("sh_req", data_req, 1'b1);
        check("sh_wr", data_wr, 1'b1);
        check("sh_size", data_size, 2'd1);
        check("sh_wstrb", data_wstrb, 4'b1100);
        check("sh_wdata", data_wdata, 32'hABCD_ABCD);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        check("sh_over", MEM_over, 1'b1);
        check("sh_result", MEM_result, 32'h0000_1002);
        tick();
        MEM_valid = 1'b0;

        // sb at 0x1001
        MEM_valid = 1'b1; EXE_MEM_bus_r = mk_in(0, 1, 2'd0, 0, 32'h1234_565A, 32'h0000_1001, 5'd0, 32'hBFC0_0018);
        tick();
        data_addr_ok = 1'b1;
        #1;
        check("sb_wstrb", data_wstrb, 4'b0010);
        check("sb_wdata", data_wdata, 32'h5A5A_5A5A);
        check("sb_addr", data_addr, 32'h0000_1001);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        tick();
        MEM_valid = 1'b0;
        #1;
        check("sb_after", MEM_over, 1'b0);

        // misaligned lw at 0x1002
`ifdef MEM_ADDR_CHECK_EN
        MEM_valid = 1'b1; WB_allow_in = 1'b1;
        EXE_MEM_bus_r = mk_in(1, 0, 2'd2, 0, 32'h0, 32'h0000_1002, 5'd4, 32'hBFC0_001C);
        #1;
        check("adel_req", data_req, 1'b0);
        check("adel_over", MEM_over, 1'b1);
        check("adel_flag", MEM_WB_bus[65], 1'b1);
        check("adel_ades", MEM_WB_bus[64], 1'b0);
        check("adel_badv", MEM_WB_bus[63:32], 32'h0000_1002);
        check("adel_allow", MEM_allow_in, 1'b1);
        tick();
        MEM_valid = 1'b0;
        #1;
        check("adel_after_req", data_req, 1'b0);
        check("adel_after_over", MEM_over, 1'b0);
`else
        run_load("lw_unal", mk_in(1, 0, 2'd2, 0, 32'h0, 32'h0000_1002, 5'd4, 32'hBFC0_001C),
                 32'h0000_1000, 32'h1357_2468, 32'h1357_2468,
                 mk_wb(5'd4, 32'h1357_2468, 0, 0, 32'h0, 32'hBFC0_001C));
`endif

        // non-memory instruction: same-cycle completion, then one stalled by write-back
        MEM_valid = 1'b1; WB_allow_in = 1'b1;
        EXE_MEM_bus_r = mk_in(0, 0, 2'd0, 0, 32'h0, 32'h0000_55AA, 5'd7, 32'hBFC0_0020);
        #1;
        check("alu_over", MEM_over, 1'b1);
        check("alu_req", data_req, 1'b0);
        check("alu_result", MEM_result, 32'h0000_55AA);
        check("alu_wdest", MEM_wdest, 5'd7);
        check("alu_allow", MEM_allow_in, 1'b1);
        check("alu_wbbus", MEM_WB_bus, mk_wb(5'd7, 32'h0000_55AA, 0, 0, 32'h0, 32'hBFC0_0020));
        tick();
        EXE_MEM_bus_r = mk_in(0, 0, 2'd0, 0, 32'h0, 32'h0000_66BB, 5'd3, 32'hBFC0_0024);
        WB_allow_in = 1'b0;
        #1;
        check("alu2_over", MEM_over, 1'b1);
        check("alu2_allow", MEM_allow_in, 1'b0);
        tick();
        #1;
        check("alu2_hold_over", MEM_over, 1'b1);
        check("alu2_hold_res", MEM_result, 32'h0000_66BB);
        WB_allow_in = 1'b1;
        #1;
        check("alu2_allow_rise", MEM_allow_in, 1'b1);
        tick();
        MEM_valid = 1'b0;
        #1;
        check("alu2_after", MEM_over, 1'b0);
        check("alu2_wdest0", MEM_wdest, 5'd0);

        // cancel while still in IDLE: no request ever raised
        MEM_valid = 1'b1; cancel = 1'b1;
        EXE_MEM_bus_r = mk_in(1, 0, 2'd2, 0, 32'h0, 32'h0000_1010, 5'd2, 32'hBFC0_0028);
        #1;
        check("cidle_over", MEM_over, 1'b0);
        tick();
        MEM_valid = 1'b0; cancel = 1'b0;
        #1;
        check("cidle_req", data_req, 1'b0);
        tick();

        // cancel during WAIT, data_ok three cycles later
        MEM_valid = 1'b1;
        EXE_MEM_bus_r = mk_in(1, 0, 2'd2, 0, 32'h0, 32'h0000_1008, 5'd10, 32'hBFC0_002C);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; cancel = 1'b1; MEM_valid = 1'b0;
        #1;
        check("cw0_over", MEM_over, 1'b0);
        check("cw0_allow", MEM_allow_in, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            cancel = 1'b0;
            #1;
            check($sformatf("cw%0d_over", i), MEM_over, 1'b0);
            check($sformatf("cw%0d_allow", i), MEM_allow_in, 1'b0);
            check($sformatf("cw%0d_req", i), data_req, 1'b0);
        end
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        #1;
        check("cw3_allow", MEM_allow_in, 1'b0);
        check("cw3_over", MEM_over, 1'b0);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        check("cdrain_allow", MEM_allow_in, 1'b1);
        check("cdrain_over", MEM_over, 1'b0);
        check("cdrain_req", data_req, 1'b0);

        // write-back stall in DONE
        MEM_valid = 1'b1; WB_allow_in = 1'b1;
        EXE_MEM_bus_r = mk_in(1, 0, 2'd2, 0, 32'h0, 32'h0000_100C, 5'd11, 32'hBFC0_0030);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0; WB_allow_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("stall%0d_over", i), MEM_over, 1'b1);
            check($sformatf("stall%0d_allow", i), MEM_allow_in, 1'b0);
            check($sformatf("stall%0d_wbbus", i), MEM_WB_bus,
                  mk_wb(5'd11, 32'hCAFE_F00D, 0, 0, 32'h0, 32'hBFC0_0030));
            tick();
        end
        WB_allow_in = 1'b1;
        #1;
        check("stall_release_over", MEM_over, 1'b1);
        check("stall_release_allow", MEM_allow_in, 1'b1);
        tick();
        MEM_valid = 1'b0;
        #1;
        check("stall_single_handoff", MEM_over, 1'b0);

        // reset asserted while in REQ (sw at 0x2000)
        MEM_valid = 1'b1;
        EXE_MEM_bus_r = mk_in(0, 1, 2'd2, 0, 32'h1122_3344, 32'h0000_2000, 5'd0, 32'hBFC0_0034);
        tick();
        #1;
        check("sw_req", data_req, 1'b1);
        check("sw_wstrb", data_wstrb, 4'b1111);
        check("sw_wdata", data_wdata, 32'h1122_3344);
        reset = 1'b1;
        #1;
        check("rstreq_req", data_req, 1'b0);
        check("rstreq_over", MEM_over, 1'b0);
        MEM_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        #1;
        check("post_rst_req", data_req, 1'b0);
        check("post_rst_allow", MEM_allow_in, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline, sitting between the execute stage and write-back.
- Takes the registered execute-to-memory bus and issues at most one data-memory transaction per instruction over a request/response handshake.
- Aligns and extends load data, and detects load/store address errors.
- Produces the 153-bit memory-to-write-back bus that write-back consumes.

Parameters:
- ADDR_CHECK, 1, reserved; must stay 1 (alignment checking is controlled only by the macro below)
- BUS_IN_W, 156, width of EXE_MEM_bus_r
- BUS_OUT_W, 153, width of MEM_WB_bus

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- MEM_valid  in  1  stage holds a valid instruction
- EXE_MEM_bus_r  in  156  {mem_ctrl[4:0]={ld,st,size[1:0],uns}, store_data, exe_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, brk, eret, wen, wdest[4:0], pc}, MSB first
- WB_allow_in  in  1  write-back can accept this cycle
- cancel  in  1  exception/eret flush from write-back
- MEM_over  out  1  result ready for write-back
- MEM_allow_in  out  1  stage can accept a new instruction next cycle
- MEM_WB_bus  out  153  {wen, wdest, mem_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, brk, eret, adel, ades, badvaddr, pc}
- MEM_wdest  out  5  destination register for hazard detection; 0 when MEM_valid=0
- MEM_result  out  32  forwarding value; valid only when MEM_over=1
- data_req  out  1  memory request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  byte address
- data_wstrb  out  4  byte enables
- data_wdata  out  32  store data replicated to lanes
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response or write completion
- data_rdata  in  32  load data

Behaviour:
- Reset values:
  - State is IDLE.
  - data_req=0; MEM_over=0; MEM_allow_in=1.
  - Load-data register is 0; drop flag is 0.
- States:
  - IDLE → REQ when MEM_valid, (ld|st), no address error and no cancel; otherwise → DONE on the same cycle.
  - REQ: data_req=1 with all request fields held stable; data_addr_ok → WAIT.
  - WAIT: data_data_ok → capture data_rdata → DONE.
  - DONE: MEM_over=1; MEM_over & WB_allow_in → IDLE.
- Non-memory instructions and faulting memory instructions: MEM_over=MEM_valid combinationally in IDLE, so they complete with zero added latency.
- Best-case load/store latency: REQ 1 cycle plus WAIT 1 cycle, with MEM_over in the third cycle.
- MEM_allow_in = !MEM_valid | (MEM_over & WB_allow_in).
- Address errors:
  - adel = ld & misaligned; ades = st & misaligned.
  - Misaligned means half-word with addr[0]=1, or word with addr[1:0]≠0.
  - badvaddr = exe_result when adel|ades, otherwise 0.
  - A faulting access never raises data_req.
- Store lanes:
  - Byte: wstrb = 1<<addr[1:0]; wdata = {4{b}}.
  - Half-word: wstrb = 0011 or 1100; wdata = {2{h}}.
  - Word: wstrb = 1111.
- Load result: select the lane by addr[1:0], then sign-extend, or zero-extend when uns=1.
- mem_result source: the extended load data for loads, otherwise exe_result.
- Cancel:
  - In IDLE or REQ before addr_ok: return to IDLE with no request issued; MEM_over=0.
  - In WAIT: set the drop flag, continue waiting for data_data_ok, discard the data, then go to IDLE. MEM_allow_in=0 until the drain completes, so outstanding transactions are never more than one.
  - In DONE: go to IDLE.
- Simultaneous data_addr_ok and data_data_ok in the same cycle are illegal from memory; the block ignores data_data_ok in REQ.
- Asynchronous reset mid-transaction returns to IDLE immediately; the memory side is reset together with the core.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined: alignment checking as specified above.
- Undefined:
  - adel, ades and badvaddr are tied to 0.
  - The low address bits are forced aligned (addr[0]=0 for half-word, addr[1:0]=0 for word) before the request is issued.
  - Every memory instruction issues a request.

Decomposition:
- Shared package mem_pkg:
  - State encoding MEM_IDLE/REQ/WAIT/DONE.
  - Size codes SZ_B/SZ_H/SZ_W.
  - Bus widths 156 and 153.
  - Field offsets of both buses.
- One natural sub-module, mem_align: purely combinational; generates store strobes and data, and extracts and extends load data.

Test Plan:
- lw at 0x0000_1004, memory returns 0xDEADBEEF with addr_ok and data_ok one cycle apart → data_wstrb=0, MEM_over in the third cycle, mem_result=0xDEADBEEF.
- lb at 0x1003, rdata=0x80112233 → mem_result=0xFFFFFF80; lbu at the same address → 0x00000080.
- sh at 0x1002, data 0x0000ABCD → data_wr=1, wstrb=1100, wdata=0xABCDABCD.
- lw at 0x1002 with MEM_ADDR_CHECK_EN defined → no data_req, adel=1, badvaddr=0x1002, MEM_over the same cycle.
- cancel asserted during WAIT, data_ok arriving three cycles later → MEM_over stays 0, MEM_allow_in=0 until data_ok, no write-back bus emitted.
- WB_allow_in=0 for two cycles during DONE → MEM_WB_bus held stable, single handoff when WB_allow_in rises; reset asserted while in REQ → data_req drops immediately.
